// File: rtl/m68k_bus_master.sv
// m68k_bus_master: runs one 68000-style asynchronous bus cycle (read or write) per accepted request.
// Latency: a read completes 5 edges after it is accepted and a write 6 edges after, when DTACK answers at once.
// Backpressure: a request is sampled only in IDLE, so REQ raised while BUSY is ignored until the cycle that pulses DONE.
// Ports:
//   CLK, RST            clock and reset (synchronous, active-low)
//   i_req*              request strobe (level), direction, byte address, write data, byte enables
//   o_busy/o_done/o_err transaction status; o_done pulses for one cycle, and o_err is valid with it
//   o_rdata             last successful read data, held until the next read completes
//   o_addr_out..o_data_oe  registered bus drive (A23:A1, active-low AS/UDS/LDS, RW, data out, drive enable)
//   i_data_in, i_dtack, i_berr  bus read data and active-low responses
module m68k_bus_master #(
    parameter int TIMEOUT_CYCLES = 64   // legal range 2..255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_req,
    input  logic        i_req_rw,
    input  logic [23:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    input  logic [1:0]  i_req_be,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_rdata,
    output logic [22:0] o_addr_out,
    output logic        o_as,
    output logic        o_uds,
    output logic        o_lds,
    output logic        o_rw,
    output logic [15:0] o_data_out,
    output logic        o_data_oe,
    input  logic [15:0] i_data_in,
    input  logic        i_dtack,
    input  logic        i_berr
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ASSERT, S_WDS, S_WAIT, S_TERM, S_RECOVER
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [1:0]  r_be;
    logic        r_err_flag;

    logic        r_busy, r_done, r_err, r_as, r_uds, r_lds, r_rw, r_doe;
    logic [15:0] r_rdata, r_dout;
    logic [22:0] r_addr;

    logic        w_busy_nxt, w_done_nxt, w_err_nxt, w_as_nxt, w_uds_nxt, w_lds_nxt, w_rw_nxt, w_doe_nxt;
    logic [15:0] w_rdata_nxt, w_dout_nxt;
    logic [22:0] w_addr_nxt;

    logic        w_cnt_last;
    logic        w_release;
    logic        w_accept;
    logic        w_unused;

    // Address bit 0 is meaningless on a 16-bit bus; byte lanes come from the enables.
    assign w_unused   = i_req_addr[0];
    assign w_cnt_last = (r_cnt == LP_CNT_LAST);
    assign w_release  = i_dtack & i_berr;
    assign w_accept   = i_req & (i_req_be != 2'b00);

    // State register, plus the timeout counter and the sticky error flag.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_be       <= 2'b00;
            r_err_flag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Counter restarts on every state change, so it counts edges spent in WAIT or RECOVER.
            if (w_state_nxt != r_state)
                r_cnt <= 8'd0;
            else if (r_state == S_WAIT || r_state == S_RECOVER)
                r_cnt <= r_cnt + 8'd1;

            if (r_state == S_IDLE && w_accept) begin
                r_be       <= i_req_be;
                r_err_flag <= 1'b0;
            end else if (r_state == S_WAIT) begin
                // BERR wins over DTACK; DTACK arriving on the last edge still counts as success.
                if (!i_berr || (i_dtack && w_cnt_last))
                    r_err_flag <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_ADDR;
            S_ADDR:    w_state_nxt = S_ASSERT;
            S_ASSERT:  w_state_nxt = r_rw ? S_WAIT : S_WDS;
            S_WDS:     w_state_nxt = S_WAIT;
            S_WAIT:    if (!i_berr || !i_dtack || w_cnt_last) w_state_nxt = S_TERM;
            S_TERM:    w_state_nxt = S_RECOVER;
            S_RECOVER: if (w_release || w_cnt_last) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = r_rdata;
        w_addr_nxt  = r_addr;
        w_as_nxt    = r_as;
        w_uds_nxt   = r_uds;
        w_lds_nxt   = r_lds;
        w_rw_nxt    = r_rw;
        w_dout_nxt  = r_dout;
        w_doe_nxt   = r_doe;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_addr_nxt = i_req_addr[23:1];
                    w_rw_nxt   = i_req_rw;
                    w_dout_nxt = i_req_wdata;
                    w_doe_nxt  = ~i_req_rw;
                    w_busy_nxt = 1'b1;
                end else if (i_req) begin
                    // No byte lanes enabled: reject without touching the bus.
                    w_done_nxt = 1'b1;
                    w_err_nxt  = 1'b1;
                end
            end
            S_ADDR: begin
                w_as_nxt = 1'b0;
                if (r_rw) begin
                    w_uds_nxt = ~r_be[1];
                    w_lds_nxt = ~r_be[0];
                end
            end
            S_ASSERT: begin
                // Writes raise the data strobes one cycle after AS, once data has settled.
                if (!r_rw) begin
                    w_uds_nxt = ~r_be[1];
                    w_lds_nxt = ~r_be[0];
                end
            end
            S_WAIT: begin
                if (w_state_nxt == S_TERM) begin
                    w_as_nxt  = 1'b1;
                    w_uds_nxt = 1'b1;
                    w_lds_nxt = 1'b1;
                    if (i_berr && !i_dtack && r_rw)
                        w_rdata_nxt = i_data_in;
                end
            end
            S_TERM: begin
                w_rw_nxt  = 1'b1;
                w_doe_nxt = 1'b0;
            end
            S_RECOVER: begin
                if (w_state_nxt == S_IDLE) begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                    w_err_nxt  = w_release ? r_err_flag : 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 16'h0000;
            r_addr  <= 23'd0;
            r_as    <= 1'b1;
            r_uds   <= 1'b1;
            r_lds   <= 1'b1;
            r_rw    <= 1'b1;
            r_dout  <= 16'h0000;
            r_doe   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            r_addr  <= w_addr_nxt;
            r_as    <= w_as_nxt;
            r_uds   <= w_uds_nxt;
            r_lds   <= w_lds_nxt;
            r_rw    <= w_rw_nxt;
            r_dout  <= w_dout_nxt;
            r_doe   <= w_doe_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_rdata    = r_rdata;
    assign o_addr_out = r_addr;
    assign o_as       = r_as;
    assign o_uds      = r_uds;
    assign o_lds      = r_lds;
    assign o_rw       = r_rw;
    assign o_data_out = r_dout;
    assign o_data_oe  = r_doe;

endmodule

// File: tb/tb_m68k_bus_master.sv
// tb_m68k_bus_master: directed bench for m68k_bus_master with a simple responder model.
// Latency: checks are taken 1 time unit after each rising edge, counted from the request edge k.
// Backpressure: the responder ties DTACK/BERR to AS, or forces them to fixed levels.
module tb_m68k_bus_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req = 1'b0;
    logic        req_rw = 1'b1;
    logic [23:0] req_addr = 24'd0;
    logic [15:0] req_wdata = 16'd0;
    logic [1:0]  req_be = 2'b00;
    logic [15:0] data_in = 16'd0;
    logic        dtack_follow = 1'b1;
    logic        dtack_force = 1'b1;
    logic        berr_follow = 1'b0;

    logic        busy, done, err, as_n, uds_n, lds_n, rw, data_oe;
    logic [15:0] rdata, data_out;
    logic [22:0] addr_out;
    logic        dtack, berr;

    int n_checks = 0;
    int n_errors = 0;

    assign dtack = dtack_follow ? as_n : dtack_force;
    assign berr  = berr_follow  ? as_n : 1'b1;

    always #5 CLK = ~CLK;

    m68k_bus_master #(.TIMEOUT_CYCLES(64)) u_dut (
        .CLK(CLK), .RST(RST),
        .i_req(req), .i_req_rw(req_rw), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_be(req_be),
        .o_busy(busy), .o_done(done), .o_err(err), .o_rdata(rdata),
        .o_addr_out(addr_out), .o_as(as_n), .o_uds(uds_n), .o_lds(lds_n),
        .o_rw(rw), .o_data_out(data_out), .o_data_oe(data_oe),
        .i_data_in(data_in), .i_dtack(dtack), .i_berr(berr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a request for exactly one edge (edge k); returns just after edge k.
    task automatic start_req(input logic rw_i, input logic [23:0] a, input logic [1:0] be, input logic [15:0] wd);
        req_rw = rw_i; req_addr = a; req_be = be; req_wdata = wd;
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        // Reset state
        ticks(3);
        check("rst_as", as_n, 1); check("rst_uds", uds_n, 1); check("rst_lds", lds_n, 1);
        check("rst_rw", rw, 1); check("rst_oe", data_oe, 0); check("rst_busy", busy, 0);
        check("rst_done", done, 0); check("rst_err", err, 0); check("rst_addr", addr_out, 0);
        check("rst_dout", data_out, 0); check("rst_rdata", rdata, 0);
        RST = 1'b1;
        tick();

        // Word read, DTACK follows AS
        data_in = 16'hBEEF;
        start_req(1'b1, 24'h100000, 2'b11, 16'h0000);
        check("rd_busy", busy, 1); check("rd_addr", addr_out, 23'h080000); check("rd_rw", rw, 1);
        check("rd_as_k0", as_n, 1);
        tick();
        check("rd_as_k1", as_n, 0); check("rd_uds_k1", uds_n, 0); check("rd_lds_k1", lds_n, 0);
        ticks(2);
        check("rd_as_k3", as_n, 1); check("rd_uds_k3", uds_n, 1); check("rd_lds_k3", lds_n, 1);
        tick();
        check("rd_done_k4", done, 0);
        tick();
        check("rd_done_k5", done, 1); check("rd_err_k5", err, 0);
        check("rd_rdata_k5", rdata, 16'hBEEF); check("rd_busy_k5", busy, 0);
        tick();
        check("rd_done_k6", done, 0);

        // Lower byte write
        start_req(1'b0, 24'h100003, 2'b01, 16'h00A5);
        check("wr_oe_k0", data_oe, 1); check("wr_rw_k0", rw, 0);
        check("wr_dout", data_out, 16'h00A5); check("wr_addr", addr_out, 23'h080001);
        tick();
        check("wr_as_k1", as_n, 0); check("wr_uds_k1", uds_n, 1); check("wr_lds_k1", lds_n, 1);
        tick();
        check("wr_lds_k2", lds_n, 0); check("wr_uds_k2", uds_n, 1); check("wr_oe_k2", data_oe, 1);
        tick();
        check("wr_lds_k3", lds_n, 0);
        tick();
        check("wr_as_k4", as_n, 1); check("wr_lds_k4", lds_n, 1); check("wr_oe_k4", data_oe, 1);
        tick();
        check("wr_oe_k5", data_oe, 0); check("wr_rw_k5", rw, 1); check("wr_done_k5", done, 0);
        tick();
        check("wr_done_k6", done, 1); check("wr_err_k6", err, 0); check("wr_rdata_keep", rdata, 16'hBEEF);

        // DTACK never arrives: WAIT timeout after 64 edges
        dtack_follow = 1'b0; dtack_force = 1'b1;
        data_in = 16'h1234;
        start_req(1'b1, 24'h000200, 2'b11, 16'h0000);
        ticks(2);
        ticks(63);
        check("to_as_k65", as_n, 0);
        tick();
        check("to_as_k66", as_n, 1); check("to_uds_k66", uds_n, 1);
        tick();
        check("to_done_k67", done, 0);
        tick();
        check("to_done_k68", done, 1); check("to_err_k68", err, 1); check("to_rdata", rdata, 16'hBEEF);
        tick();

        // DTACK and BERR low together: BERR wins
        dtack_follow = 1'b1; berr_follow = 1'b1;
        data_in = 16'h5555;
        start_req(1'b1, 24'h000400, 2'b11, 16'h0000);
        ticks(4);
        check("berr_done_k4", done, 0);
        tick();
        check("berr_done_k5", done, 1); check("berr_err_k5", err, 1); check("berr_rdata", rdata, 16'hBEEF);
        berr_follow = 1'b0;
        tick();

        // Empty byte enables: immediate error, no bus activity
        start_req(1'b1, 24'h000600, 2'b00, 16'h0000);
        check("be0_done", done, 1); check("be0_err", err, 1); check("be0_busy", busy, 0); check("be0_as", as_n, 1);
        tick();
        check("be0_done_k1", done, 0); check("be0_as_k1", as_n, 1);

        // DTACK stuck low: RECOVER timeout
        dtack_follow = 1'b0; dtack_force = 1'b0;
        data_in = 16'h7777;
        start_req(1'b1, 24'h000800, 2'b11, 16'h0000);
        ticks(67);
        check("rto_done_k67", done, 0); check("rto_as_k67", as_n, 1);
        tick();
        check("rto_done_k68", done, 1); check("rto_err_k68", err, 1); check("rto_busy_k68", busy, 0);
        dtack_force = 1'b1;
        tick();

        // Reset in WAIT, then a normal read
        start_req(1'b1, 24'h000A00, 2'b11, 16'h0000);
        ticks(3);
        check("rstw_as_pre", as_n, 0);
        RST = 1'b0;
        tick();
        check("rstw_as", as_n, 1); check("rstw_uds", uds_n, 1); check("rstw_lds", lds_n, 1);
        check("rstw_oe", data_oe, 0); check("rstw_busy", busy, 0); check("rstw_done", done, 0);
        check("rstw_rdata", rdata, 0);
        RST = 1'b1;
        dtack_follow = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstw_no_done", done, 0);
        end
        data_in = 16'hCAFE;
        start_req(1'b1, 24'h100000, 2'b11, 16'h0000);
        ticks(5);
        check("rstw_rd_done", done, 1); check("rstw_rd_err", err, 0); check("rstw_rd_rdata", rdata, 16'hCAFE);
        tick();

        // Back-to-back: REQ held high across DONE
        data_in = 16'hBEEF;
        req_rw = 1'b1; req_addr = 24'h100000; req_be = 2'b11;
        req = 1'b1;
        tick();
        ticks(3);
        check("b2b_as_k3", as_n, 1);
        tick();
        check("b2b_as_k4", as_n, 1);
        tick();
        check("b2b_done_k5", done, 1); check("b2b_busy_k5", busy, 0); check("b2b_as_k5", as_n, 1);
        tick();
        req = 1'b0;
        check("b2b_busy_k6", busy, 1); check("b2b_done_k6", done, 0); check("b2b_as_k6", as_n, 1);
        tick();
        check("b2b_as_k7", as_n, 0);
        ticks(4);
        check("b2b_done_k11", done, 1); check("b2b_err_k11", err, 0); check("b2b_rdata", rdata, 16'hBEEF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent waiting for DTACK/BERR (WAIT) or for their release (RECOVER); legal range 2-255.
REQ-002 CLK  in  1  system clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-low.
REQ-004 REQ  in  1  request strobe, level; sampled only in IDLE.
REQ-005 REQ_RW  in  1  1=read, 0=write.
REQ-006 REQ_ADDR  in  24  byte address; bit 0 ignored.
REQ-007 REQ_WDATA  in  16  write data.
REQ-008 REQ_BE  in  2  byte enables; bit1=upper (D15:8), bit0=lower (D7:0).
REQ-009 BUSY  out  1  transaction in progress.
REQ-010 DONE  out  1  one-cycle completion pulse.
REQ-011 ERR  out  1  valid with DONE; 1=bus error/timeout/illegal request.
REQ-012 RDATA  out  16  read data; valid with DONE, held until next read completes.
REQ-013 ADDR_OUT  out  23  bus address A23:A1.
REQ-014 AS, UDS, LDS  out  1 each  active-low strobes.
REQ-015 RW  out  1  bus direction, 1=read.
REQ-016 DATA_OUT  out  16  write data bus; DATA_OE  out  1  drive enable.
REQ-017 DATA_IN  in  16  read data bus; DTACK, BERR  in  1 each  active-low responses.

Function
REQ-018 All outputs SHALL be registered; states: IDLE, ADDR, ASSERT, WDS, WAIT, TERM, RECOVER.
REQ-019 IDLE: REQ=1 with REQ_BE!=0 SHALL latch all REQ_* fields, load ADDR_OUT=REQ_ADDR[23:1], RW=REQ_RW, DATA_OUT=REQ_WDATA, DATA_OE=~REQ_RW, set BUSY=1, go ADDR.
REQ-020 IDLE: REQ=1 with REQ_BE=0 SHALL produce DONE=1, ERR=1 for one cycle with no bus activity and stay IDLE.
REQ-021 ADDR -> ASSERT: AS=0; for read, UDS=~BE[1], LDS=~BE[0] asserted with AS.
REQ-022 ASSERT -> WAIT (read) or WDS (write); WDS asserts UDS/LDS per BE, -> WAIT.
REQ-023 WAIT: BERR=0 -> TERM with error flag; else DTACK=0 -> TERM, RDATA<=DATA_IN if read; BERR wins when both low same edge.
REQ-024 WAIT: 8-bit counter cleared on WAIT entry; after TIMEOUT_CYCLES edges in WAIT with neither response -> TERM with error flag.
REQ-025 TERM: AS, UDS, LDS <= 1; RW, ADDR_OUT, DATA_OUT, DATA_OE held; -> RECOVER.
REQ-026 RECOVER: on entry RW<=1, DATA_OE<=0; when DTACK=1 and BERR=1 sampled -> IDLE, DONE=1, ERR=error flag, BUSY=0.
REQ-027 RECOVER: after TIMEOUT_CYCLES edges without release -> IDLE, DONE=1, ERR=1.
REQ-028 REQ during BUSY SHALL be ignored; REQ high in the cycle DONE is high SHALL start a new transaction (back-to-back).
REQ-029 On error, RDATA SHALL NOT be updated.
REQ-030 Strobes SHALL never be low outside ASSERT/WDS/WAIT; DATA_OE SHALL never be 1 while RW=1.

Reset
REQ-031 RST=0 at any edge, including mid-transaction, SHALL force IDLE, AS=UDS=LDS=1, RW=1, DATA_OE=0, BUSY=0, DONE=0, ERR=0, ADDR_OUT=0, DATA_OUT=0, RDATA=0, counter=0.
REQ-032 No partial DONE SHALL be issued for a transaction aborted by reset.

Verification
REQ-033 Read, REQ at edge k, addr 0x100000, BE=11, responder DTACK=AS, DATA_IN=0xBEEF -> AS low after k+1, UDS/LDS low after k+1, strobes high after k+3, DONE=1/ERR=0/RDATA=0xBEEF after k+5.
REQ-034 Write byte, addr 0x100003, BE=01, data 0x00A5 -> UDS stays high, LDS low one cycle after AS, DATA_OE=1 from k+1 through TERM, DONE after k+6, ERR=0.
REQ-035 DTACK held high, TIMEOUT_CYCLES=64 -> strobes release after 64 WAIT cycles, DONE=1, ERR=1, RDATA unchanged.
REQ-036 DTACK and BERR both low in same WAIT cycle -> ERR=1 with DONE; BE=00 request -> DONE+ERR next cycle, AS never low.
REQ-037 RST low while in WAIT -> next edge all strobes high, DATA_OE=0, BUSY=0, no DONE; subsequent read completes normally.
REQ-038 REQ held high across DONE -> second transaction's ADDR state begins the edge after DONE, AS high for at least 3 cycles between transactions.
